fifo_param: RTL and testbench

Parametrised token FIFO for the CGRA inter-PE datapath, successor to the fixed 4-entry FIFO. Adds configurable width and depth, an asynchronous reset that can pre-load initial tokens (for loop-carried dependences), simultaneous read/write when full, an occupancy count with an almost-full flag, and sticky overflow/underflow error flags in place of simulation-only assertions. It sits on every PE input channel between the upstream producer's write strobe and the PE's firing logic.

---
 rtl/fifo_param.sv | 142 ++++++++++++++
 tb/tb_fifo_param.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// fifo_param: parametrised token FIFO for a CGRA PE input channel.
// Width, depth and reset pre-load are configurable. A read and a write can
// both be accepted in the same cycle at any occupancy, including full.
// Status outputs are registered, and refused accesses set sticky error flags.
module fifo_param #(
    parameter int                   DATA_SIZE   = 8,
    parameter int                   DEPTH       = 4,
    parameter int                   INIT_TOKENS = 0,
    parameter logic [DATA_SIZE-1:0] INIT_VALUE  = '0,
    parameter int                   ALMOST_FULL = DEPTH - 1,
    localparam int                  CW          = $clog2(DEPTH + 1),
    localparam int                  AW          = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] inData,
    input  logic                 write,
    input  logic                 read,
    output logic [DATA_SIZE-1:0] outData,
    output logic                 isFull,
    output logic                 isEmpty,
    output logic                 almostFull,
    output logic [CW-1:0]        count,
    output logic                 overflow,
    output logic                 underflow
);

    // Reset images of the control state, derived from the pre-load count.
    localparam logic [AW-1:0] WHEAD_RST  = AW'(INIT_TOKENS % DEPTH);
    localparam logic [CW-1:0] COUNT_RST  = CW'(INIT_TOKENS);
    localparam logic          EMPTY_RST  = (INIT_TOKENS == 0);
    localparam logic          FULL_RST   = (INIT_TOKENS == DEPTH);
    localparam logic          ALMOST_RST = (INIT_TOKENS >= ALMOST_FULL);

    logic [DATA_SIZE-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]     entry_we;

    logic [AW-1:0] read_head_q,  read_head_d;
    logic [AW-1:0] write_head_q, write_head_d;
    logic [CW-1:0] count_q,      count_d;
    logic          full_q,       full_d;
    logic          empty_q,      empty_d;
    logic          almost_q,     almost_d;
    logic          overflow_q,   overflow_d;
    logic          underflow_q,  underflow_d;

    logic read_acc;
    logic write_acc;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [AW-1:0] ptr_adv(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // A full FIFO still takes a write when the head leaves in the same cycle.
    // An empty FIFO never bypasses, so a read there is always refused.
    assign read_acc  = read && !empty_q;
    assign write_acc = write && (!full_q || read_acc);

    // Per-entry write enable decoded from the write pointer.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign entry_we[gi] = write_acc && (write_head_q == AW'(gi));
        end
    endgenerate

    // Next-state for pointers, occupancy, status and sticky error flags.
    always_comb begin
        read_head_d  = read_head_q;
        write_head_d = write_head_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;

        if (read_acc) begin
            read_head_d = ptr_adv(read_head_q);
        end
        if (write_acc) begin
            write_head_d = ptr_adv(write_head_q);
        end

        count_d = count_q + {{(CW-1){1'b0}}, write_acc} - {{(CW-1){1'b0}}, read_acc};

        if (write && !write_acc) begin
            overflow_d = 1'b1;
        end
        if (read && !read_acc) begin
            underflow_d = 1'b1;
        end

        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
        almost_d = (count_d >= CW'(ALMOST_FULL));
    end

    // Control state register; reset restores the pre-loaded occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_head_q  <= '0;
            write_head_q <= WHEAD_RST;
            count_q      <= COUNT_RST;
            full_q       <= FULL_RST;
            empty_q      <= EMPTY_RST;
            almost_q     <= ALMOST_RST;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            read_head_q  <= read_head_d;
            write_head_q <= write_head_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            almost_q     <= almost_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Token storage; the first INIT_TOKENS entries reset to INIT_VALUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= (i < INIT_TOKENS) ? INIT_VALUE : '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_we[i]) begin
                    regs_q[i] <= inData;
                end
            end
        end
    end

    assign outData    = regs_q[read_head_q];
    assign isFull     = full_q;
    assign isEmpty    = empty_q;
    assign almostFull = almost_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: scoreboard bench for fifo_param across several parameter sets.
module tb_fifo_param;

    logic clk;
    logic rst;

    int total;
    int bad;

    // Instance A: DEPTH=4, empty at reset.
    logic [7:0] a_in, a_out;
    logic       a_write, a_read, a_full, a_empty, a_af, a_ovf, a_udf;
    logic [2:0] a_cnt;
    // Instance B: DEPTH=5, non-power-of-two.
    logic [7:0] b_in, b_out;
    logic       b_write, b_read, b_full, b_empty, b_af, b_ovf, b_udf;
    logic [2:0] b_cnt;
    // Instance C: DEPTH=4, one pre-loaded zero token.
    logic [7:0] c_in, c_out;
    logic       c_write, c_read, c_full, c_empty, c_af, c_ovf, c_udf;
    logic [2:0] c_cnt;
    // Instance D: DEPTH=4, fully pre-loaded with 0x77.
    logic [7:0] d_in, d_out;
    logic       d_write, d_read, d_full, d_empty, d_af, d_ovf, d_udf;
    logic [2:0] d_cnt;

    fifo_param #(.DATA_SIZE(8), .DEPTH(4), .INIT_TOKENS(0), .INIT_VALUE(8'h00), .ALMOST_FULL(3)) dut_a (
        .clk(clk), .rst(rst), .inData(a_in), .write(a_write), .read(a_read),
        .outData(a_out), .isFull(a_full), .isEmpty(a_empty), .almostFull(a_af),
        .count(a_cnt), .overflow(a_ovf), .underflow(a_udf));

    fifo_param #(.DATA_SIZE(8), .DEPTH(5), .INIT_TOKENS(0), .INIT_VALUE(8'h00), .ALMOST_FULL(4)) dut_b (
        .clk(clk), .rst(rst), .inData(b_in), .write(b_write), .read(b_read),
        .outData(b_out), .isFull(b_full), .isEmpty(b_empty), .almostFull(b_af),
        .count(b_cnt), .overflow(b_ovf), .underflow(b_udf));

    fifo_param #(.DATA_SIZE(8), .DEPTH(4), .INIT_TOKENS(1), .INIT_VALUE(8'h00), .ALMOST_FULL(3)) dut_c (
        .clk(clk), .rst(rst), .inData(c_in), .write(c_write), .read(c_read),
        .outData(c_out), .isFull(c_full), .isEmpty(c_empty), .almostFull(c_af),
        .count(c_cnt), .overflow(c_ovf), .underflow(c_udf));

    fifo_param #(.DATA_SIZE(8), .DEPTH(4), .INIT_TOKENS(4), .INIT_VALUE(8'h77), .ALMOST_FULL(3)) dut_d (
        .clk(clk), .rst(rst), .inData(d_in), .write(d_write), .read(d_read),
        .outData(d_out), .isFull(d_full), .isEmpty(d_empty), .almostFull(d_af),
        .count(d_cnt), .overflow(d_ovf), .underflow(d_udf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboards and reference flag state.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic       ma_ovf, ma_udf, mb_ovf, mb_udf;
    logic       a_hv, b_hv;
    logic [7:0] a_hexp, a_hgot, b_hexp, b_hgot;

    // One cycle on A: drive at negedge, score head on accepted read, settle after posedge.
    task automatic step_a(input logic w, input logic r, input logic [7:0] d);
        bit ra, wa;
        @(negedge clk);
        a_write = w; a_read = r; a_in = d;
        ra = r && (qa.size() != 0);
        wa = w && ((qa.size() != 4) || ra);
        #1;
        a_hv = ra;
        if (ra) begin a_hexp = qa.pop_front(); a_hgot = a_out; end
        if (wa) qa.push_back(d);
        if (w && !wa) ma_ovf = 1'b1;
        if (r && !ra) ma_udf = 1'b1;
        @(posedge clk); #1;
        a_write = 1'b0; a_read = 1'b0;
    endtask

    task automatic step_b(input logic w, input logic r, input logic [7:0] d);
        bit ra, wa;
        @(negedge clk);
        b_write = w; b_read = r; b_in = d;
        ra = r && (qb.size() != 0);
        wa = w && ((qb.size() != 5) || ra);
        #1;
        b_hv = ra;
        if (ra) begin b_hexp = qb.pop_front(); b_hgot = b_out; end
        if (wa) qb.push_back(d);
        if (w && !wa) mb_ovf = 1'b1;
        if (r && !ra) mb_udf = 1'b1;
        @(posedge clk); #1;
        b_write = 1'b0; b_read = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #2;
        total++; if (a_cnt !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", a_cnt); end
        total++; if (a_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", a_empty); end
        total++; if ({a_full, a_af, a_ovf, a_udf} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {a_full, a_af, a_ovf, a_udf}); end
        total++; if (b_cnt !== 3'd0 || b_empty !== 1'b1) begin bad++; $display("FAIL reset_b got=%0d/%b exp=0/1", b_cnt, b_empty); end
        @(negedge clk);
        rst = 1'b0;
        $display("reset: a count=%0d empty=%b", a_cnt, a_empty);
    endtask

    task automatic test_init_tokens();
        total++; if (c_cnt !== 3'd1 || c_empty !== 1'b0) begin bad++; $display("FAIL init1_status got=%0d/%b exp=1/0", c_cnt, c_empty); end
        total++; if (c_out !== 8'h00) begin bad++; $display("FAIL init1_data got=%h exp=00", c_out); end
        total++; if (d_full !== 1'b1 || d_cnt !== 3'd4 || d_af !== 1'b1) begin bad++; $display("FAIL initfull_status got=%b/%0d/%b exp=1/4/1", d_full, d_cnt, d_af); end
        total++; if (d_out !== 8'h77) begin bad++; $display("FAIL initfull_data got=%h exp=77", d_out); end
        @(negedge clk);
        c_read = 1'b1; d_read = 1'b1;
        @(posedge clk); #1;
        c_read = 1'b0; d_read = 1'b0;
        total++; if (c_cnt !== 3'd0 || c_empty !== 1'b1 || c_udf !== 1'b0) begin bad++; $display("FAIL init1_read got=%0d/%b/%b exp=0/1/0", c_cnt, c_empty, c_udf); end
        total++; if (d_cnt !== 3'd3 || d_full !== 1'b0 || d_af !== 1'b1 || d_out !== 8'h77) begin bad++; $display("FAIL initfull_read got=%0d/%b/%b/%h exp=3/0/1/77", d_cnt, d_full, d_af, d_out); end
        $display("init_tokens: c count=%0d d count=%0d", c_cnt, d_cnt);
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            step_a(1'b1, 1'b0, 8'(8'h11 * (i + 1)));
            total++; if (a_cnt !== 3'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, a_cnt, i + 1); end
            total++; if (a_af !== (i >= 2) || a_full !== (i == 3) || a_empty !== 1'b0) begin bad++; $display("FAIL fill_flags[%0d] got af=%b full=%b empty=%b exp af=%b full=%b empty=0", i, a_af, a_full, a_empty, i >= 2, i == 3); end
            $display("fill: wrote %h count=%0d", 8'(8'h11 * (i + 1)), a_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            step_a(1'b0, 1'b1, 8'h00);
            total++; if (!a_hv || a_hgot !== a_hexp) begin bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, a_hgot, a_hexp); end
            total++; if (a_cnt !== 3'(3 - i) || a_empty !== (i == 3)) begin bad++; $display("FAIL drain_count[%0d] got=%0d/%b exp=%0d/%b", i, a_cnt, a_empty, 3 - i, i == 3); end
            $display("drain: read %h count=%0d", a_hgot, a_cnt);
        end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 4; i++) step_a(1'b1, 1'b0, 8'(8'hA0 + i));
        for (int i = 0; i < 3; i++) begin
            step_a(1'b1, 1'b1, 8'hAB);
            total++; if (a_hgot !== a_hexp) begin bad++; $display("FAIL fullrw_data[%0d] got=%h exp=%h", i, a_hgot, a_hexp); end
            total++; if (a_cnt !== 3'd4 || a_full !== 1'b1 || a_ovf !== 1'b0) begin bad++; $display("FAIL fullrw_status[%0d] got=%0d/%b/%b exp=4/1/0", i, a_cnt, a_full, a_ovf); end
            $display("full_rw: read %h wrote ab count=%0d", a_hgot, a_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            step_a(1'b0, 1'b1, 8'h00);
            total++; if (a_hgot !== a_hexp) begin bad++; $display("FAIL fullrw_drain[%0d] got=%h exp=%h", i, a_hgot, a_hexp); end
            $display("full_rw drain: read %h", a_hgot);
        end
        total++; if (a_empty !== 1'b1 || a_ovf !== ma_ovf) begin bad++; $display("FAIL fullrw_end got=%b/%b exp=1/%b", a_empty, a_ovf, ma_ovf); end
    endtask

    task automatic test_underflow();
        step_a(1'b0, 1'b1, 8'h00);
        total++; if (a_udf !== 1'b1 || a_cnt !== 3'd0) begin bad++; $display("FAIL udf_set got=%b/%0d exp=1/0", a_udf, a_cnt); end
        step_a(1'b1, 1'b1, 8'h5A);
        total++; if (a_cnt !== 3'd1 || a_out !== 8'h5A || a_empty !== 1'b0) begin bad++; $display("FAIL udf_rw got=%0d/%h/%b exp=1/5a/0", a_cnt, a_out, a_empty); end
        total++; if (a_udf !== ma_udf) begin bad++; $display("FAIL udf_sticky got=%b exp=%b", a_udf, ma_udf); end
        step_a(1'b0, 1'b1, 8'h00);
        total++; if (a_hgot !== a_hexp || a_cnt !== 3'd0) begin bad++; $display("FAIL udf_drain got=%h/%0d exp=%h/0", a_hgot, a_cnt, a_hexp); end
        $display("underflow: udf=%b count=%0d", a_udf, a_cnt);
    endtask

    task automatic test_nonpow2();
        // Keeps occupancy between 3 and 5 while 12 tokens pass through.
        logic [1:0] pat [12] = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10,
                                 2'b11, 2'b01, 2'b01, 2'b10, 2'b11, 2'b10};
        int wn = 0;
        for (int i = 0; i < 3; i++) begin step_b(1'b1, 1'b0, 8'(8'h30 + wn)); wn++; end
        for (int i = 0; i < 12; i++) begin
            step_b(pat[i][1], pat[i][0], 8'(8'h30 + wn));
            if (pat[i][1]) wn++;
            if (b_hv) begin
                total++; if (b_hgot !== b_hexp) begin bad++; $display("FAIL np2_data[%0d] got=%h exp=%h", i, b_hgot, b_hexp); end
            end
            total++; if (b_cnt !== 3'(qb.size()) || b_full !== (qb.size() == 5) || b_af !== (qb.size() >= 4)) begin bad++; $display("FAIL np2_status[%0d] got=%0d/%b/%b exp=%0d", i, b_cnt, b_full, b_af, qb.size()); end
            $display("np2: w=%b r=%b count=%0d", pat[i][1], pat[i][0], b_cnt);
        end
        while (qb.size() != 0) begin
            step_b(1'b0, 1'b1, 8'h00);
            total++; if (b_hgot !== b_hexp) begin bad++; $display("FAIL np2_drain got=%h exp=%h", b_hgot, b_hexp); end
            $display("np2 drain: read %h", b_hgot);
        end
        total++; if (wn != 12 || b_empty !== 1'b1 || b_ovf !== 1'b0 || b_udf !== 1'b0) begin bad++; $display("FAIL np2_end got writes=%0d empty=%b ovf=%b udf=%b exp 12/1/0/0", wn, b_empty, b_ovf, b_udf); end
    endtask

    task automatic test_overflow_reset();
        for (int i = 0; i < 4; i++) step_a(1'b1, 1'b0, 8'(8'hC0 + i));
        step_a(1'b1, 1'b0, 8'hEE);
        total++; if (a_ovf !== 1'b1 || a_cnt !== 3'd4 || a_out !== 8'hC0) begin bad++; $display("FAIL ovf_set got=%b/%0d/%h exp=1/4/c0", a_ovf, a_cnt, a_out); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (a_cnt !== 3'd0 || a_ovf !== 1'b0 || a_udf !== 1'b0 || a_empty !== 1'b1 || a_full !== 1'b0) begin bad++; $display("FAIL async_reset got cnt=%0d ovf=%b udf=%b empty=%b full=%b exp 0/0/0/1/0", a_cnt, a_ovf, a_udf, a_empty, a_full); end
        #1 rst = 1'b0;
        qa.delete(); ma_ovf = 1'b0; ma_udf = 1'b0;
        step_a(1'b1, 1'b0, 8'h99);
        total++; if (a_cnt !== 3'd1 || a_out !== 8'h99) begin bad++; $display("FAIL post_reset got=%0d/%h exp=1/99", a_cnt, a_out); end
        $display("overflow_reset: count=%0d out=%h", a_cnt, a_out);
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b0;
        ma_ovf = 1'b0; ma_udf = 1'b0; mb_ovf = 1'b0; mb_udf = 1'b0;
        a_hv = 1'b0; b_hv = 1'b0;
        a_hexp = '0; a_hgot = '0; b_hexp = '0; b_hgot = '0;
        a_in = '0; a_write = 1'b0; a_read = 1'b0;
        b_in = '0; b_write = 1'b0; b_read = 1'b0;
        c_in = '0; c_write = 1'b0; c_read = 1'b0;
        d_in = '0; d_write = 1'b0; d_read = 1'b0;
        test_reset();
        test_init_tokens();
        test_fill_drain();
        test_full_rw();
        test_underflow();
        test_nonpow2();
        test_overflow_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit reached");
    end

endmodule
